// File: rtl/countdown_timer_bcd.sv
// Four-digit BCD mm:ss countdown timer feeding the VGA text painter.
// Ports:
//   clk_100MHz, reset (async, active-high)
//   load, start_pause, clear             : one-cycle control pulses (debounced upstream)
//   set_mDecimal/set_mUnit/set_sDecimal/set_sUnit : preset digits latched on a valid load
//   mDecimal/mUnit/sDecimal/sUnit        : current time, registered BCD
//   actualState                          : FSM code (IDLE=0 LOADED=1 RUNNING=2 PAUSED=3 DONE=4)
//   finish                               : high while in DONE
//   tick                                 : one-cycle pulse, registered with each decrement
//   load_err                             : one-cycle pulse when a load is rejected
module countdown_timer_bcd #(
   parameter int unsigned CLK_FREQ_HZ = 100000000,
   parameter int unsigned PRESCALE_W  = 27
) (
   input  logic       clk_100MHz,
   input  logic       reset,
   input  logic       load,
   input  logic       start_pause,
   input  logic       clear,
   input  logic [3:0] set_mDecimal,
   input  logic [3:0] set_mUnit,
   input  logic [3:0] set_sDecimal,
   input  logic [3:0] set_sUnit,
   output logic [3:0] mDecimal,
   output logic [3:0] mUnit,
   output logic [3:0] sDecimal,
   output logic [3:0] sUnit,
   output logic [2:0] actualState,
   output logic       finish,
   output logic       tick,
   output logic       load_err
);

   localparam logic [PRESCALE_W-1:0] PRESCALE_MAX = PRESCALE_W'(CLK_FREQ_HZ - 1);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      LOADED  = 3'd1,
      RUNNING = 3'd2,
      PAUSED  = 3'd3,
      DONE    = 3'd4
   } state_t;

   state_t                state, state_nxt;
   logic [PRESCALE_W-1:0] prescale, prescale_nxt;
   logic [3:0]            md_nxt, mu_nxt, sd_nxt, su_nxt;
   logic [3:0]            dec_md, dec_mu, dec_sd, dec_su;
   logic                  finish_nxt, tick_nxt, load_err_nxt;
   logic                  load_ok_c, tick_due_c, cur_zero_c, dec_zero_c;

   assign actualState = state;

   // Preset must be legal BCD with seconds tens <= 5 and must not be 00:00.
   assign load_ok_c = (set_mDecimal <= 4'd9) && (set_mUnit <= 4'd9) &&
                      (set_sDecimal <= 4'd5) && (set_sUnit <= 4'd9) &&
                      ({set_mDecimal, set_mUnit, set_sDecimal, set_sUnit} != 16'd0);

   assign tick_due_c = (state == RUNNING) && (prescale == PRESCALE_MAX);
   assign cur_zero_c = ({mDecimal, mUnit, sDecimal, sUnit} == 16'd0);
   assign dec_zero_c = ({dec_md, dec_mu, dec_sd, dec_su} == 16'd0);

   // One-second BCD decrement with borrow chain; 00:00 is held, never wrapped.
   always_comb begin
      dec_md = mDecimal;
      dec_mu = mUnit;
      dec_sd = sDecimal;
      dec_su = sUnit;
      if (!cur_zero_c) begin
         if (sUnit != 4'd0) begin
            dec_su = sUnit - 4'd1;
         end else begin
            dec_su = 4'd9;
            if (sDecimal != 4'd0) begin
               dec_sd = sDecimal - 4'd1;
            end else begin
               dec_sd = 4'd5;
               if (mUnit != 4'd0) begin
                  dec_mu = mUnit - 4'd1;
               end else begin
                  dec_mu = 4'd9;
                  dec_md = mDecimal - 4'd1;
               end
            end
         end
      end
   end

   // Next-state and next-output logic; clear > load > start_pause/tick.
   always_comb begin
      state_nxt    = state;
      prescale_nxt = prescale;
      md_nxt       = mDecimal;
      mu_nxt       = mUnit;
      sd_nxt       = sDecimal;
      su_nxt       = sUnit;
      tick_nxt     = 1'b0;
      load_err_nxt = 1'b0;

      if (clear) begin
         state_nxt    = IDLE;
         prescale_nxt = '0;
         md_nxt       = 4'd0;
         mu_nxt       = 4'd0;
         sd_nxt       = 4'd0;
         su_nxt       = 4'd0;
      end else if (load) begin
         // A pending tick is discarded whenever a load is present.
         if (load_ok_c) begin
            state_nxt    = LOADED;
            prescale_nxt = '0;
            md_nxt       = set_mDecimal;
            mu_nxt       = set_mUnit;
            sd_nxt       = set_sDecimal;
            su_nxt       = set_sUnit;
         end else begin
            load_err_nxt = 1'b1;
         end
      end else begin
         case (state)
            IDLE: begin
            end
            LOADED: begin
               if (start_pause) begin
                  state_nxt    = RUNNING;
                  prescale_nxt = '0;
               end
            end
            RUNNING: begin
               if (tick_due_c) begin
                  prescale_nxt = '0;
                  tick_nxt     = 1'b1;
                  md_nxt       = dec_md;
                  mu_nxt       = dec_mu;
                  sd_nxt       = dec_sd;
                  su_nxt       = dec_su;
                  if (dec_zero_c)       state_nxt = DONE;
                  else if (start_pause) state_nxt = PAUSED;
               end else begin
                  prescale_nxt = prescale + PRESCALE_W'(1);
                  if (start_pause) state_nxt = PAUSED;
               end
            end
            PAUSED: begin
               if (start_pause) state_nxt = RUNNING;
            end
            DONE: begin
            end
            default: state_nxt = IDLE;
         endcase
      end

      finish_nxt = (state_nxt == DONE);
   end

   // State, time digits and pulse outputs, all registered together.
   always_ff @(posedge clk_100MHz or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         prescale <= '0;
         mDecimal <= 4'd0;
         mUnit    <= 4'd0;
         sDecimal <= 4'd0;
         sUnit    <= 4'd0;
         finish   <= 1'b0;
         tick     <= 1'b0;
         load_err <= 1'b0;
      end else begin
         state    <= state_nxt;
         prescale <= prescale_nxt;
         mDecimal <= md_nxt;
         mUnit    <= mu_nxt;
         sDecimal <= sd_nxt;
         sUnit    <= su_nxt;
         finish   <= finish_nxt;
         tick     <= tick_nxt;
         load_err <= load_err_nxt;
      end
   end

endmodule

// File: tb/tb_countdown_timer_bcd.sv
// Self-checking bench for countdown_timer_bcd with a 10-cycle second.
// Directed vector table, hand-written countdown/pause/reset sequences, then
// random pulses checked against a seconds-based reference model.
module tb_countdown_timer_bcd;

   localparam int unsigned F = 10;

   logic       clk_100MHz;
   logic       reset;
   logic       load, start_pause, clear;
   logic [3:0] set_mDecimal, set_mUnit, set_sDecimal, set_sUnit;
   logic [3:0] mDecimal, mUnit, sDecimal, sUnit;
   logic [2:0] actualState;
   logic       finish, tick, load_err;

   int errors = 0;
   int checks = 0;

   countdown_timer_bcd #(.CLK_FREQ_HZ(F), .PRESCALE_W(4)) dut (
      .clk_100MHz  (clk_100MHz),
      .reset       (reset),
      .load        (load),
      .start_pause (start_pause),
      .clear       (clear),
      .set_mDecimal(set_mDecimal),
      .set_mUnit   (set_mUnit),
      .set_sDecimal(set_sDecimal),
      .set_sUnit   (set_sUnit),
      .mDecimal    (mDecimal),
      .mUnit       (mUnit),
      .sDecimal    (sDecimal),
      .sUnit       (sUnit),
      .actualState (actualState),
      .finish      (finish),
      .tick        (tick),
      .load_err    (load_err)
   );

   initial clk_100MHz = 1'b0;
   always #5 clk_100MHz = ~clk_100MHz;

   initial begin
      #2000000;
      $display("FAIL timeout: simulation did not finish (errors=%0d)", errors);
      $fatal(1, "timeout");
   end

   typedef struct {
      logic       ld, sp, clr;
      logic [3:0] p_md, p_mu, p_sd, p_su;
      logic [3:0] e_md, e_mu, e_sd, e_su;
      logic [2:0] e_st;
      logic       e_fin, e_tk, e_err;
   } vec_t;

   vec_t vecs[13];

   // Reference model: time kept as total seconds, prescaler as a plain count.
   int m_state, m_secs, m_pre;
   int m_tick, m_err;

   task automatic model_step(input int ld, input int sp, input int clr,
                             input int a, input int b, input int c, input int d);
      m_tick = 0;
      m_err  = 0;
      if (clr != 0) begin
         m_state = 0; m_secs = 0; m_pre = 0;
      end else if (ld != 0) begin
         if (a <= 9 && b <= 9 && c <= 5 && d <= 9 && (a + b + c + d) != 0) begin
            m_secs  = (a * 10 + b) * 60 + c * 10 + d;
            m_state = 1;
            m_pre   = 0;
         end else begin
            m_err = 1;
         end
      end else if (m_state == 1) begin
         if (sp != 0) begin m_state = 2; m_pre = 0; end
      end else if (m_state == 2) begin
         if (m_pre == int'(F) - 1) begin
            m_pre  = 0;
            m_secs = m_secs - 1;
            m_tick = 1;
            if (m_secs == 0)  m_state = 4;
            else if (sp != 0) m_state = 3;
         end else begin
            m_pre = m_pre + 1;
            if (sp != 0) m_state = 3;
         end
      end else if (m_state == 3) begin
         if (sp != 0) m_state = 2;
      end
   endtask

   task automatic chk(input string nm, input int md, input int mu, input int sd, input int su,
                      input int st, input int fin, input int tk, input int err);
      logic [21:0] got, exp;
      got = {mDecimal, mUnit, sDecimal, sUnit, actualState, finish, tick, load_err};
      exp = {4'(md), 4'(mu), 4'(sd), 4'(su), 3'(st), 1'(fin), 1'(tk), 1'(err)};
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got mm:ss=%h%h:%h%h st=%0d fin=%b tick=%b err=%b, expected mm:ss=%h%h:%h%h st=%0d fin=%b tick=%b err=%b",
                  nm, got[21:18], got[17:14], got[13:10], got[9:6], got[5:3], got[2], got[1], got[0],
                  exp[21:18], exp[17:14], exp[13:10], exp[9:6], exp[5:3], exp[2], exp[1], exp[0]);
      end
   endtask

   // Apply one cycle of inputs; returns 1 time unit after the active edge.
   task automatic step(input logic ld, input logic sp, input logic clr,
                       input logic [3:0] a, input logic [3:0] b,
                       input logic [3:0] c, input logic [3:0] d);
      load = ld; start_pause = sp; clear = clr;
      set_mDecimal = a; set_mUnit = b; set_sDecimal = c; set_sUnit = d;
      @(posedge clk_100MHz);
      #1;
      load = 1'b0; start_pause = 1'b0; clear = 1'b0;
   endtask

   task automatic idle();
      step(1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 4'd0);
   endtask

   initial begin
      int pv, ld, sp, clr, a, b, c, d;

      // ld sp clr | preset | expected digits | state fin tick err
      vecs[0]  = '{0,0,0, 0,0,0,0,   0,0,0,0, 0, 0,0,0};
      vecs[1]  = '{0,1,0, 0,0,0,0,   0,0,0,0, 0, 0,0,0};
      vecs[2]  = '{1,0,0, 0,0,6,0,   0,0,0,0, 0, 0,0,1};
      vecs[3]  = '{1,0,0, 1,10,0,0,  0,0,0,0, 0, 0,0,1};
      vecs[4]  = '{1,0,0, 0,0,0,0,   0,0,0,0, 0, 0,0,1};
      vecs[5]  = '{1,0,0, 0,5,3,0,   0,5,3,0, 1, 0,0,0};
      vecs[6]  = '{1,0,0, 0,0,6,0,   0,5,3,0, 1, 0,0,1};
      vecs[7]  = '{1,0,1, 1,2,3,4,   0,0,0,0, 0, 0,0,0};
      vecs[8]  = '{1,1,0, 0,1,0,0,   0,1,0,0, 1, 0,0,0};
      vecs[9]  = '{0,1,0, 0,0,0,0,   0,1,0,0, 2, 0,0,0};
      vecs[10] = '{0,1,0, 0,0,0,0,   0,1,0,0, 3, 0,0,0};
      vecs[11] = '{0,0,1, 0,0,0,0,   0,0,0,0, 0, 0,0,0};
      vecs[12] = '{1,0,0, 9,9,5,9,   9,9,5,9, 1, 0,0,0};

      reset = 1'b1;
      load = 1'b0; start_pause = 1'b0; clear = 1'b0;
      set_mDecimal = 4'd0; set_mUnit = 4'd0; set_sDecimal = 4'd0; set_sUnit = 4'd0;
      repeat (3) @(posedge clk_100MHz);
      #1;
      chk("reset_state", 0,0,0,0, 0, 0,0,0);
      reset = 1'b0;

      foreach (vecs[i]) begin
         step(vecs[i].ld, vecs[i].sp, vecs[i].clr,
              vecs[i].p_md, vecs[i].p_mu, vecs[i].p_sd, vecs[i].p_su);
         chk($sformatf("vec%0d", i), vecs[i].e_md, vecs[i].e_mu, vecs[i].e_sd, vecs[i].e_su,
             vecs[i].e_st, vecs[i].e_fin, vecs[i].e_tk, vecs[i].e_err);
      end

      // 01:00 counted all the way down to DONE.
      step(1, 0, 0, 4'd0, 4'd1, 4'd0, 4'd0);
      chk("A_load", 0,1,0,0, 1, 0,0,0);
      step(0, 1, 0, 4'd0, 4'd0, 4'd0, 4'd0);
      chk("A_start", 0,1,0,0, 2, 0,0,0);
      for (int t = 59; t >= 0; t--) begin
         pv = t + 1;
         for (int k = 0; k < int'(F) - 1; k++) begin
            idle();
            chk("A_wait", 0, pv / 60, (pv % 60) / 10, pv % 10, 2, 0,0,0);
         end
         idle();
         chk("A_tick", 0,0, t / 10, t % 10, (t == 0) ? 4 : 2, (t == 0) ? 1 : 0, 1, 0);
      end
      for (int k = 0; k < 20; k++) begin
         idle();
         chk("A_done_hold", 0,0,0,0, 4, 1,0,0);
      end
      step(0, 1, 0, 4'd0, 4'd0, 4'd0, 4'd0);
      chk("A_sp_in_done", 0,0,0,0, 4, 1,0,0);

      // Full borrow chain 10:00 -> 09:59, then 00:01 -> DONE.
      step(1, 0, 0, 4'd1, 4'd0, 4'd0, 4'd0);
      chk("B_load", 1,0,0,0, 1, 0,0,0);
      step(0, 1, 0, 4'd0, 4'd0, 4'd0, 4'd0);
      chk("B_start", 1,0,0,0, 2, 0,0,0);
      for (int k = 0; k < int'(F) - 1; k++) begin
         idle();
         chk("B_wait", 1,0,0,0, 2, 0,0,0);
      end
      idle();
      chk("B_borrow", 0,9,5,9, 2, 0,1,0);
      step(1, 0, 0, 4'd0, 4'd0, 4'd0, 4'd1);
      chk("B_load1", 0,0,0,1, 1, 0,0,0);
      step(0, 1, 0, 4'd0, 4'd0, 4'd0, 4'd0);
      chk("B_start1", 0,0,0,1, 2, 0,0,0);
      for (int k = 0; k < int'(F) - 1; k++) begin
         idle();
         chk("B_wait1", 0,0,0,1, 2, 0,0,0);
      end
      idle();
      chk("B_done", 0,0,0,0, 4, 1,1,0);

      // Pause preserves the partial second.
      step(1, 0, 0, 4'd0, 4'd0, 4'd3, 4'd0);
      chk("C_load", 0,0,3,0, 1, 0,0,0);
      step(0, 1, 0, 4'd0, 4'd0, 4'd0, 4'd0);
      chk("C_start", 0,0,3,0, 2, 0,0,0);
      for (int k = 0; k < 3; k++) begin
         idle();
         chk("C_run", 0,0,3,0, 2, 0,0,0);
      end
      step(0, 1, 0, 4'd0, 4'd0, 4'd0, 4'd0);
      chk("C_pause", 0,0,3,0, 3, 0,0,0);
      for (int k = 0; k < 50; k++) begin
         idle();
         chk("C_paused", 0,0,3,0, 3, 0,0,0);
      end
      step(0, 1, 0, 4'd0, 4'd0, 4'd0, 4'd0);
      chk("C_resume", 0,0,3,0, 2, 0,0,0);
      for (int k = 0; k < 5; k++) begin
         idle();
         chk("C_resume_wait", 0,0,3,0, 2, 0,0,0);
      end
      idle();
      chk("C_tick", 0,0,2,9, 2, 0,1,0);

      // Tick coinciding with start_pause: decrement applied, state PAUSED.
      for (int k = 0; k < int'(F) - 1; k++) begin
         idle();
         chk("D_wait", 0,0,2,9, 2, 0,0,0);
      end
      step(0, 1, 0, 4'd0, 4'd0, 4'd0, 4'd0);
      chk("D_tick_pause", 0,0,2,8, 3, 0,1,0);
      for (int k = 0; k < 5; k++) begin
         idle();
         chk("D_hold", 0,0,2,8, 3, 0,0,0);
      end

      // Asynchronous reset mid-run, then no ticks afterwards.
      step(0, 1, 0, 4'd0, 4'd0, 4'd0, 4'd0);
      chk("E_resume", 0,0,2,8, 2, 0,0,0);
      for (int k = 0; k < 3; k++) idle();
      reset = 1'b1;
      #1;
      chk("E_async_reset", 0,0,0,0, 0, 0,0,0);
      @(posedge clk_100MHz);
      @(posedge clk_100MHz);
      #1;
      reset = 1'b0;
      for (int k = 0; k < 30; k++) begin
         idle();
         chk("E_after_reset", 0,0,0,0, 0, 0,0,0);
      end

      // Random pulses against the seconds-based model.
      m_state = 0; m_secs = 0; m_pre = 0;
      for (int n = 0; n < 6000; n++) begin
         clr = ($urandom_range(0, 499) == 0) ? 1 : 0;
         ld  = ($urandom_range(0, 299) == 0) ? 1 : 0;
         sp  = ($urandom_range(0, 24) == 0) ? 1 : 0;
         if (m_state == 0 && $urandom_range(0, 19) == 0) ld = 1;
         if ($urandom_range(0, 4) == 0) begin
            a = int'($urandom_range(0, 15)); b = int'($urandom_range(0, 15));
            c = int'($urandom_range(0, 15)); d = int'($urandom_range(0, 15));
         end else begin
            a = 0; b = int'($urandom_range(0, 1));
            c = int'($urandom_range(0, 2)); d = int'($urandom_range(0, 9));
         end
         step(1'(ld), 1'(sp), 1'(clr), 4'(a), 4'(b), 4'(c), 4'(d));
         model_step(ld, sp, clr, a, b, c, d);
         chk($sformatf("rand%0d", n), (m_secs / 60) / 10, (m_secs / 60) % 10,
             (m_secs % 60) / 10, m_secs % 10, m_state, (m_state == 4) ? 1 : 0, m_tick, m_err);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/countdown_timer_bcd.md
Name: countdown_timer_bcd

Overview:
- Four-digit BCD mm:ss countdown timer that feeds the VGA text path: mDecimal, mUnit, sDecimal, sUnit, actualState and finish.
- Sits between the button/switch front end and the VGA painter.
- Accepts a preset time, counts down once per second from an internal prescaler, supports pause/resume, and signals completion.
- All outputs are registered and stable between ticks, so the painter samples them asynchronously to its pixel timing without glitches.

Parameters:
- CLK_FREQ_HZ, 100000000, input clock cycles per one-second tick; must be >= 2. Benches use small values such as 10.
- PRESCALE_W, 27, prescaler counter width; must hold CLK_FREQ_HZ-1.

Ports:
- clk_100MHz  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- load  in  1  one-cycle pulse: latch the preset digits.
- start_pause  in  1  one-cycle pulse: start, pause or resume.
- clear  in  1  one-cycle pulse: return to IDLE and zero the time.
- set_mDecimal  in  4  preset minutes tens, 0-9.
- set_mUnit  in  4  preset minutes units, 0-9.
- set_sDecimal  in  4  preset seconds tens, 0-5.
- set_sUnit  in  4  preset seconds units, 0-9.
- mDecimal  out  4  current minutes tens (BCD).
- mUnit  out  4  current minutes units.
- sDecimal  out  4  current seconds tens.
- sUnit  out  4  current seconds units.
- actualState  out  3  FSM state code.
- finish  out  1  high while in DONE.
- tick  out  1  one-cycle pulse on each decrement.
- load_err  out  1  one-cycle pulse when a load is rejected.

Behaviour:
- Reset (async, active-high):
  - All digits 0; actualState = IDLE (3'd0).
  - finish = 0, tick = 0, load_err = 0.
  - Prescaler = 0.
- Control inputs are synchronous one-cycle pulses, already debounced upstream.
- State codes: IDLE = 0, LOADED = 1, RUNNING = 2, PAUSED = 3, DONE = 4. Codes 5-7 are unreachable; if entered, the next cycle goes to IDLE.
- Priority when several pulses arrive in the same cycle: clear > load > start_pause.
- clear, in any state:
  - Next cycle: IDLE, digits 00:00, prescaler 0, finish 0.
- load, in any state:
  - Valid load (all digits <= 9, set_sDecimal <= 5, preset not 00:00): digits take the preset values next cycle, state = LOADED, prescaler = 0, finish = 0.
  - Invalid load (any digit out of range, or preset is 00:00): digits and state unchanged, load_err pulses for 1 cycle.
- start_pause transitions:
  - LOADED -> RUNNING, with prescaler cleared.
  - RUNNING -> PAUSED.
  - PAUSED -> RUNNING.
  - Ignored in IDLE and DONE.
- Prescaler:
  - Increments only in RUNNING.
  - When it reaches CLK_FREQ_HZ-1, it wraps to 0 and a tick is generated that cycle.
  - Holds its value in PAUSED, so the partial second is preserved across a pause.
  - The first tick after LOADED->RUNNING comes exactly CLK_FREQ_HZ cycles after the start_pause pulse.
- Tick (RUNNING only): the tick output pulses in the same cycle the digits update (registered together). Decrement with BCD borrow:
  - sUnit > 0: sUnit--.
  - Otherwise sUnit = 9 and borrow from sDecimal.
  - sDecimal borrow: if > 0 decrement, otherwise sDecimal = 5 and borrow from mUnit.
  - mUnit borrow: if > 0 decrement, otherwise mUnit = 9 and mDecimal--.
  - Never underflows: 00:00 is terminal.
- DONE:
  - If the decremented value is 00:00, the state becomes DONE in the same cycle the digits show 00:00.
  - finish = 1 from that cycle on.
  - Digits hold at 00:00.
  - The prescaler stops.
  - Exit only via load or clear.
- Simultaneous tick and start_pause in RUNNING: the decrement is applied and the state moves to PAUSED.
- Simultaneous tick and load, or tick and clear: the load or clear wins and the tick is discarded; the tick output stays 0.
- Reset asserted mid-count: all outputs return to reset values immediately (asynchronously). No tick may occur until a new load and start.
- Digit outputs never show a non-BCD value, and sDecimal never exceeds 5.

Test Plan:
- Reset with CLK_FREQ_HZ=10 -> digits 0000, actualState=0, finish=0. Assert reset mid-RUNNING -> same values immediately; no tick afterwards.
- Load 01:00, then start_pause -> actualState=2. First tick 10 cycles later shows 00:59. After 59 further ticks: 00:00, actualState=4, finish=1, digits hold.
- Load 10:00 and run 1 tick -> 09:59, exercising borrow through all four digits. Load 00:01, 1 tick -> DONE.
- Load 00:30, start, pause after 4 cycles, wait 50 cycles -> digits still 00:30 and no tick. Resume -> first tick exactly 6 cycles later shows 00:29.
- Load with set_sDecimal=6, then 1A:00, then 00:00 -> load_err pulses each time; state and digits unchanged. start_pause in IDLE -> ignored.
- clear and load in the same cycle -> IDLE, 00:00. load and start_pause in the same cycle -> LOADED, not RUNNING. Tick coinciding with start_pause -> value decremented, actualState=3.
